rv_decode_stage: RTL and testbench
==================================

// Module: rv_decode_stage
// PURPOSE
//  Decode stage feeding the register-file/ALU stage. Accepts 32-bit RV32I words over a
//  valid/ready handshake and emits registered rs1/rs2/rd, func3/func5, imm and the control
//  bits the reg+ALU stage consumes. A 2-entry skid buffer keeps in_ready free of any
//  combinational path from out_ready.
// PARAMETERS
//  XLEN      32   instruction width; only 32 supported
//  IMM_W     12   immediate width driven on imm
// PORTS
//  clk        in   1    clock, rising edge
//  reset      in   1    asynchronous, active-low reset
//  flush      in   1    synchronous: drop all buffered instructions
//  in_valid   in   1    instr valid
//  in_ready   out  1    stage can accept instr this cycle
//  instr      in   32   instruction word
//  out_valid  out  1    decoded bundle valid
//  out_ready  in   1    downstream accepts bundle
//  rs1,rs2,rd out  5    register indices
//  func3      out  3    instr[14:12]
//  func5      out  7    instr[31:25]
//  imm        out  12   sign-bearing immediate, format per opcode
//  RegWrite,ALUSrc,PCSrc,MemRead,MemWrite,MemToReg,ALUOp0,ALUOp1  out 1 each  controls
//  illegal    out  1    bundle carries an unsupported opcode
// BEHAVIOUR
//  - Reset (async, reset==0): both entries empty; out_valid=0, in_ready=1, all data/control
//    outputs 0. Outputs stay 0 while out_valid=0.
//  - Transfer on in_valid&in_ready (in) / out_valid&out_ready (out). Latency: instr accepted
//    in cycle N appears with out_valid=1 in N+1. Throughput 1/cycle when out_ready held 1.
//  - Buffer: main reg drives outputs; skid reg catches one word when main held and a new one
//    arrives. in_ready = !skid_full (registered). Both full -> in_ready=0. Output pops main;
//    skid moves to main same edge. Order strictly FIFO; no bundle dropped or duplicated.
//  - out bundle held stable while out_valid=1 and out_ready=0.
//  - Decode ({ALUOp1,ALUOp0}; imm):
//    0110011 R   : RegWrite; ALUOp=10; imm=0
//    0010011 I   : RegWrite,ALUSrc; ALUOp=10; imm=instr[31:20]
//    0000011 LD  : RegWrite,ALUSrc,MemRead,MemToReg; ALUOp=00; imm=instr[31:20]
//    0100011 ST  : ALUSrc,MemWrite; ALUOp=00; imm={instr[31:25],instr[11:7]}; rd=0
//    1100011 BR  : PCSrc; ALUOp=01; imm={instr[31],instr[7],instr[30:25],instr[11:8]}; rd=0
//    other       : illegal=1, all controls 0, fields still passed through.
//  - RegWrite forced 0 when rd==0 (x0 writes suppressed).
//  - flush: both entries emptied next edge; same-cycle input is discarded; in_ready=1 after.
//  - flush and reset mid-transfer: nothing of the in-flight bundle may reappear.
// CONFIGURATION
//  DEC_PERF_CNT_EN defined: adds outputs instr_cnt[31:0] (increments per output transfer)
//  and illegal_cnt[15:0] (per transferred bundle with illegal=1); both wrap, reset to 0,
//  not cleared by flush. Undefined: ports and counters absent; decode unchanged.
// STRUCTURE
//  - rv_dec_pkg: opcode localparams (OP_R, OP_I, OP_LD, OP_ST, OP_BR), ALUOp encodings,
//    decoded-bundle width constant.
//  - Sub-module rv_decode_comb: pure combinational instr -> bundle; instantiated once ahead
//    of the skid buffer (decode before storage; buffer holds decoded bundles).
// TESTING
//  1 add x7,x5,x6 (0x006283B3), out_ready=1 -> next cycle rs1=5,rs2=6,rd=7,RegWrite=1,ALUOp=10,ALUSrc=0
//  2 addi x1,x0,-1 (0xFFF00093) -> ALUSrc=1,RegWrite=1,imm=0xFFF; lw x2,8(x1) (0x0080A103) -> MemRead=MemToReg=1,imm=8
//  3 sw x2,12(x1) (0x0020A623) -> MemWrite=1,imm=12,RegWrite=0; beq x1,x2,+16 (0x00208863) -> PCSrc=1,ALUOp=01,imm=0x008
//  4 out_ready=0, push 3 words -> in_ready=0 after 2nd; release -> outputs in order, none lost
//  5 instr=0xFFFFFFFF -> illegal=1, controls 0; flush with 2 buffered -> out_valid=0 next cycle
//  6 reset=0 mid-stream -> out_valid=0 immediately; with DEC_PERF_CNT_EN, counters read 0

Source files
------------

// File: rtl/rv_dec_pkg.sv
// rv_dec_pkg: shared opcode encodings, ALUOp encodings and the decoded bundle layout
// used by the RV32I decode stage.
package rv_dec_pkg;

    // Supported major opcodes (instr[6:0])
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    // {ALUOp1, ALUOp0} encodings consumed by the ALU control
    localparam logic [1:0] ALUOP_ADD  = 2'b00;  // address add (loads/stores)
    localparam logic [1:0] ALUOP_BR   = 2'b01;  // branch compare
    localparam logic [1:0] ALUOP_FUNC = 2'b10;  // operation from func3/func5

    // One decoded instruction as held in the skid buffer
    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  func3;
        logic [6:0]  func5;
        logic [11:0] imm;
        logic        reg_write;
        logic        alu_src;
        logic        pc_src;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic [1:0]  alu_op;
        logic        illegal;
    } dec_bundle_t;

    localparam int BUNDLE_W = $bits(dec_bundle_t);

endpackage

// File: rtl/rv_decode_comb.sv
// rv_decode_comb: purely combinational RV32I word -> decoded bundle.
// Unsupported opcodes set illegal, clear every control and zero imm while the
// register/func fields are still passed through.
module rv_decode_comb
    import rv_dec_pkg::*;
(
    input  logic [31:0] instr,
    output dec_bundle_t bundle
);

    // Field extraction, per-opcode controls/immediate, then x0 write suppression
    always_comb begin
        // NOTE: assigning a full default first guarantees every field is driven on every path, so no latch is inferred.
        bundle       = '0;
        bundle.rs1   = instr[19:15];
        bundle.rs2   = instr[24:20];
        bundle.rd    = instr[11:7];
        bundle.func3 = instr[14:12];
        bundle.func5 = instr[31:25];
        case (instr[6:0])
            OP_R: begin
                bundle.reg_write = 1'b1;
                bundle.alu_op    = ALUOP_FUNC;
            end
            OP_I: begin
                bundle.reg_write = 1'b1;
                bundle.alu_src   = 1'b1;
                bundle.alu_op    = ALUOP_FUNC;
                bundle.imm       = instr[31:20];
            end
            OP_LD: begin
                bundle.reg_write  = 1'b1;
                bundle.alu_src    = 1'b1;
                bundle.mem_read   = 1'b1;
                bundle.mem_to_reg = 1'b1;
                bundle.alu_op     = ALUOP_ADD;
                bundle.imm        = instr[31:20];
            end
            OP_ST: begin
                bundle.alu_src   = 1'b1;
                bundle.mem_write = 1'b1;
                bundle.alu_op    = ALUOP_ADD;
                bundle.imm       = {instr[31:25], instr[11:7]};
                bundle.rd        = 5'd0;
            end
            OP_BR: begin
                bundle.pc_src = 1'b1;
                bundle.alu_op = ALUOP_BR;
                bundle.imm    = {instr[31], instr[7], instr[30:25], instr[11:8]};
                bundle.rd     = 5'd0;
            end
            default: begin
                bundle.illegal = 1'b1;
            end
        endcase
        // Writes to x0 never reach the register file
        if (bundle.rd == 5'd0) begin
            bundle.reg_write = 1'b0;
        end
    end

endmodule

// File: rtl/rv_decode_stage.sv
// rv_decode_stage: RV32I decode stage with a 2-entry skid buffer holding decoded
// bundles. in_ready is a flop output (not skid full), so it has no combinational
// path from out_ready. Outputs read 0 whenever out_valid is 0.
// Optional build macro: DEC_PERF_CNT_EN adds instr_cnt / illegal_cnt transfer counters.
module rv_decode_stage
    import rv_dec_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int IMM_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic [2:0]       func3,
    output logic [6:0]       func5,
    output logic [IMM_W-1:0] imm,
    output logic             RegWrite,
    output logic             ALUSrc,
    output logic             PCSrc,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemToReg,
    output logic             ALUOp0,
    output logic             ALUOp1,
    output logic             illegal
`ifdef DEC_PERF_CNT_EN
    ,
    output logic [31:0]      instr_cnt,
    output logic [15:0]      illegal_cnt
`endif
);

    dec_bundle_t         dec_word;
    dec_bundle_t         out_b;
    logic [BUNDLE_W-1:0] main_q;
    logic [BUNDLE_W-1:0] skid_q;
    logic                main_valid;
    logic                skid_valid;
    logic                push;
    logic                pop;

    rv_decode_comb u_decode (
        .instr  (instr),
        .bundle (dec_word)
    );

    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign push      = in_valid && in_ready;
    assign pop       = main_valid && out_ready;

    // Skid buffer: main drives the outputs, skid catches a word arriving while main is held
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (pop) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                skid_valid <= 1'b0;
            end else if (push) begin
                main_q <= dec_word;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (push) begin
            if (!main_valid) begin
                main_q     <= dec_word;
                main_valid <= 1'b1;
            end else begin
                skid_q     <= dec_word;
                skid_valid <= 1'b1;
            end
        end
    end

    // Outputs are forced to zero while no bundle is presented
    assign out_b    = main_valid ? dec_bundle_t'(main_q) : '0;
    assign rs1      = out_b.rs1;
    assign rs2      = out_b.rs2;
    assign rd       = out_b.rd;
    assign func3    = out_b.func3;
    assign func5    = out_b.func5;
    assign imm      = out_b.imm;
    assign RegWrite = out_b.reg_write;
    assign ALUSrc   = out_b.alu_src;
    assign PCSrc    = out_b.pc_src;
    assign MemRead  = out_b.mem_read;
    assign MemWrite = out_b.mem_write;
    assign MemToReg = out_b.mem_to_reg;
    assign ALUOp0   = out_b.alu_op[0];
    assign ALUOp1   = out_b.alu_op[1];
    assign illegal  = out_b.illegal;

`ifdef DEC_PERF_CNT_EN
    // Transfer counters: count output handshakes, wrap naturally, untouched by flush
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_cnt   <= '0;
            illegal_cnt <= '0;
        end else if (pop) begin
            instr_cnt <= instr_cnt + 32'd1;
            if (out_b.illegal) begin
                illegal_cnt <= illegal_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rv_decode_stage.sv
// tb_rv_decode_stage: directed self-checking bench for rv_decode_stage.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
module tb_rv_decode_stage;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  func3;
    logic [6:0]  func5;
    logic [11:0] imm;
    logic        RegWrite, ALUSrc, PCSrc, MemRead, MemWrite, MemToReg, ALUOp0, ALUOp1;
    logic        illegal;
`ifdef DEC_PERF_CNT_EN
    logic [31:0] instr_cnt;
    logic [15:0] illegal_cnt;
`endif
    logic [7:0]  ctrl;

    int checks = 0;
    int errors = 0;

    // Instruction words and expected control vectors {RW,AS,PC,MR,MW,MTR,ALUOp1,ALUOp0}
    localparam logic [31:0] W_ADD  = 32'h006283B3;  // add  x7,x5,x6
    localparam logic [31:0] W_ADDI = 32'hFFF00093;  // addi x1,x0,-1
    localparam logic [31:0] W_LW   = 32'h0080A103;  // lw   x2,8(x1)
    localparam logic [31:0] W_SW   = 32'h0020A623;  // sw   x2,12(x1)
    localparam logic [31:0] W_BEQ  = 32'h00208863;  // beq  x1,x2,+16
    localparam logic [31:0] W_NOP  = 32'h00000013;  // addi x0,x0,0
    localparam logic [31:0] W_BAD  = 32'hFFFFFFFF;

    rv_decode_stage dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .func3     (func3),
        .func5     (func5),
        .imm       (imm),
        .RegWrite  (RegWrite),
        .ALUSrc    (ALUSrc),
        .PCSrc     (PCSrc),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .MemToReg  (MemToReg),
        .ALUOp0    (ALUOp0),
        .ALUOp1    (ALUOp1),
        .illegal   (illegal)
`ifdef DEC_PERF_CNT_EN
        ,
        .instr_cnt   (instr_cnt),
        .illegal_cnt (illegal_cnt)
`endif
    );

    assign ctrl = {RegWrite, ALUSrc, PCSrc, MemRead, MemWrite, MemToReg, ALUOp1, ALUOp0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [4:0] e_rs1, input logic [4:0] e_rs2,
                             input logic [4:0] e_rd, input logic [2:0] e_f3, input logic [6:0] e_f5,
                             input logic [11:0] e_imm, input logic [7:0] e_ctrl, input logic e_ill);
        check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
        check({tag, ".rs1"},       64'(rs1),       64'(e_rs1));
        check({tag, ".rs2"},       64'(rs2),       64'(e_rs2));
        check({tag, ".rd"},        64'(rd),        64'(e_rd));
        check({tag, ".func3"},     64'(func3),     64'(e_f3));
        check({tag, ".func5"},     64'(func5),     64'(e_f5));
        check({tag, ".imm"},       64'(imm),       64'(e_imm));
        check({tag, ".ctrl"},      64'(ctrl),      64'(e_ctrl));
        check({tag, ".illegal"},   64'(illegal),   64'(e_ill));
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".out_valid"}, 64'(out_valid), 64'd0);
        check({tag, ".fields"},    64'({rs1, rs2, rd, func3, func5, imm}), 64'd0);
        check({tag, ".ctrl"},      64'({ctrl, illegal}), 64'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        instr     = 32'd0;
        #3;
        check_idle("reset");
        check("reset.in_ready", 64'(in_ready), 64'd1);
        step();
        reset = 1'b1;
        step();

        // Stream of legal formats at full throughput
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instr     = W_ADD;
        step();
        check_out("add",  5'd5, 5'd6,  5'd7, 3'd0, 7'h00, 12'h000, 8'b1000_0010, 1'b0);
        instr = W_ADDI;
        step();
        check_out("addi", 5'd0, 5'd31, 5'd1, 3'd0, 7'h7F, 12'hFFF, 8'b1100_0010, 1'b0);
        instr = W_LW;
        step();
        check_out("lw",   5'd1, 5'd8,  5'd2, 3'd2, 7'h00, 12'h008, 8'b1101_0100, 1'b0);
        instr = W_SW;
        step();
        check_out("sw",   5'd1, 5'd2,  5'd0, 3'd2, 7'h00, 12'h00C, 8'b0100_1000, 1'b0);
        instr = W_BEQ;
        step();
        check_out("beq",  5'd1, 5'd2,  5'd0, 3'd0, 7'h00, 12'h008, 8'b0010_0001, 1'b0);
        instr = W_NOP;
        step();
        check_out("x0wr", 5'd0, 5'd0,  5'd0, 3'd0, 7'h00, 12'h000, 8'b0100_0010, 1'b0);
        in_valid = 1'b0;
        step();
        check_idle("drain");

        // Backpressure: three pushes against a stalled consumer
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = W_ADD;
        step();
        check("bp1.in_ready", 64'(in_ready), 64'd1);
        check_out("bp1", 5'd5, 5'd6, 5'd7, 3'd0, 7'h00, 12'h000, 8'b1000_0010, 1'b0);
        instr = W_ADDI;
        step();
        check("bp2.in_ready", 64'(in_ready), 64'd0);
        check_out("bp2", 5'd5, 5'd6, 5'd7, 3'd0, 7'h00, 12'h000, 8'b1000_0010, 1'b0);
        instr = W_LW;
        step();
        check("bp3.in_ready", 64'(in_ready), 64'd0);
        check_out("bp3.hold", 5'd5, 5'd6, 5'd7, 3'd0, 7'h00, 12'h000, 8'b1000_0010, 1'b0);
        out_ready = 1'b1;
        step();
        check("rel1.in_ready", 64'(in_ready), 64'd1);
        check_out("rel1", 5'd0, 5'd31, 5'd1, 3'd0, 7'h7F, 12'hFFF, 8'b1100_0010, 1'b0);
        step();
        check_out("rel2", 5'd1, 5'd8, 5'd2, 3'd2, 7'h00, 12'h008, 8'b1101_0100, 1'b0);
        in_valid = 1'b0;
        step();
        check_idle("rel3");

        // Illegal opcode, then flush with both entries occupied
        in_valid = 1'b1;
        instr    = W_BAD;
        step();
        check_out("bad", 5'd31, 5'd31, 5'd31, 3'd7, 7'h7F, 12'h000, 8'b0000_0000, 1'b1);
        out_ready = 1'b0;
        instr     = W_ADD;
        step();
        check("full.in_ready", 64'(in_ready), 64'd0);
        flush = 1'b1;
        instr = W_SW;
        step();
        check_idle("flush");
        check("flush.in_ready", 64'(in_ready), 64'd1);
        step();
        check_idle("flush.discard");
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        check_idle("flush.after");
`ifdef DEC_PERF_CNT_EN
        check("cnt.after_flush", 64'(instr_cnt), 64'd9);
        check("icnt.after_flush", 64'(illegal_cnt), 64'd0);
`endif

        // One illegal bundle actually transferred
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instr     = W_BAD;
        step();
        check("bad2.illegal", 64'(illegal), 64'd1);
        in_valid = 1'b0;
        step();
        check_idle("bad2.drain");
`ifdef DEC_PERF_CNT_EN
        check("cnt.total", 64'(instr_cnt), 64'd10);
        check("icnt.total", 64'(illegal_cnt), 64'd1);
`endif

        // Asynchronous reset with both entries full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = W_ADD;
        step();
        instr = W_LW;
        step();
        check("prerst.in_ready", 64'(in_ready), 64'd0);
        reset = 1'b0;
        #1;
        check_idle("midrst");
        check("midrst.in_ready", 64'(in_ready), 64'd1);
`ifdef DEC_PERF_CNT_EN
        check("midrst.cnt", 64'(instr_cnt), 64'd0);
        check("midrst.icnt", 64'(illegal_cnt), 64'd0);
`endif
        in_valid = 1'b0;
        step();
        reset     = 1'b1;
        out_ready = 1'b1;
        step();
        check_idle("postrst1");
        step();
        check_idle("postrst2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
